// File: rtl/spectrum_peak_ctrl_if.sv
// Signals shared by the peak-search sequencer, the modulus RAM read port
// and the downstream frequency-separation logic.
interface spectrum_peak_ctrl_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);
  logic              start;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] peak1_addr;
  logic [DATA_W-1:0] peak1_mag;
  logic [ADDR_W-1:0] peak2_addr;
  logic [DATA_W-1:0] peak2_mag;
  logic              busy;
  logic              done;

  modport master (
    input  start,
    input  rd_data,
    output rd_en,
    output rd_addr,
    output peak1_addr,
    output peak1_mag,
    output peak2_addr,
    output peak2_mag,
    output busy,
    output done
  );

  modport slave (
    output start,
    output rd_data,
    input  rd_en,
    input  rd_addr,
    input  peak1_addr,
    input  peak1_mag,
    input  peak2_addr,
    input  peak2_mag,
    input  busy,
    input  done
  );
endinterface

// File: rtl/spectrum_peak_ctrl.sv
// Scans the single-sided band of the FFT modulus RAM once per rising edge of
// start and reports the two strongest, spectrally separated peaks.
module spectrum_peak_ctrl #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 16,
  parameter int ADDR_SPAN = 2048,
  parameter int START_BIN = 1,
  parameter int RD_LAT    = 1,
  parameter int MIN_SEP   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  spectrum_peak_ctrl_if.master bus
);

  localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(START_BIN);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(ADDR_SPAN - 1);
  localparam logic [ADDR_W-1:0] SEP_ADDR   = ADDR_W'(MIN_SEP);
  localparam logic [ADDR_W-1:0] ONE_ADDR   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ZERO_ADDR  = {ADDR_W{1'b0}};
  localparam logic [DATA_W-1:0] ZERO_MAG   = {DATA_W{1'b0}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              start_dly_q, start_dly_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] p1_addr_q, p1_addr_d;
  logic [DATA_W-1:0] p1_mag_q, p1_mag_d;
  logic [ADDR_W-1:0] p2_addr_q, p2_addr_d;
  logic [DATA_W-1:0] p2_mag_q, p2_mag_d;
  logic [RD_LAT-1:0] tag_vld_q, tag_vld_d;
  logic [ADDR_W-1:0] tag_addr_q [RD_LAT];
  logic [ADDR_W-1:0] tag_addr_d [RD_LAT];

  logic              arm;
  logic              clr_peaks;
  logic              cmp_vld;
  logic [ADDR_W-1:0] cmp_addr;
  logic [DATA_W-1:0] cmp_mag;
  logic [ADDR_W-1:0] cmp_dist;
  logic              far;

  // All state registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      start_dly_q <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= ZERO_ADDR;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      p1_addr_q   <= ZERO_ADDR;
      p1_mag_q    <= ZERO_MAG;
      p2_addr_q   <= ZERO_ADDR;
      p2_mag_q    <= ZERO_MAG;
      tag_vld_q   <= {RD_LAT{1'b0}};
      for (int i = 0; i < RD_LAT; i++) begin
        tag_addr_q[i] <= ZERO_ADDR;
      end
    end else begin
      state_q     <= state_d;
      start_dly_q <= start_dly_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      p1_addr_q   <= p1_addr_d;
      p1_mag_q    <= p1_mag_d;
      p2_addr_q   <= p2_addr_d;
      p2_mag_q    <= p2_mag_d;
      tag_vld_q   <= tag_vld_d;
      for (int i = 0; i < RD_LAT; i++) begin
        tag_addr_q[i] <= tag_addr_d[i];
      end
    end
  end

  // Return tag pipeline: mirrors the RAM latency so data and bin line up
  always_comb begin
    tag_vld_d     = tag_vld_q;
    tag_addr_d    = tag_addr_q;
    tag_vld_d[0]  = rd_en_q;
    tag_addr_d[0] = rd_addr_q;
    for (int i = 1; i < RD_LAT; i++) begin
      tag_vld_d[i]  = tag_vld_q[i-1];
      tag_addr_d[i] = tag_addr_q[i-1];
    end
  end

  // Sequencer: edge detect, read issue and completion handshake
  always_comb begin
    start_dly_d = bus.start;
    arm         = bus.start & ~start_dly_q;
    state_d     = state_q;
    rd_en_d     = rd_en_q;
    rd_addr_d   = rd_addr_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    clr_peaks   = 1'b0;
    case (state_q)
      IDLE: begin
        if (arm) begin
          state_d   = SCAN;
          rd_en_d   = 1'b1;
          rd_addr_d = FIRST_ADDR;
          busy_d    = 1'b1;
          clr_peaks = 1'b1;
        end else begin
          state_d   = IDLE;
        end
      end
      SCAN: begin
        if (rd_addr_q == LAST_ADDR) begin
          rd_en_d = 1'b0;
          state_d = DRAIN;
        end else begin
          rd_addr_d = rd_addr_q + ONE_ADDR;
        end
      end
      DRAIN: begin
        // Leave once the last returning sample is being compared this cycle
        if (~|tag_vld_d) begin
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d = DRAIN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        rd_en_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Peak tracker; bins arrive in ascending order so cmp_addr >= p1_addr
  always_comb begin
    cmp_vld   = tag_vld_q[RD_LAT-1];
    cmp_addr  = tag_addr_q[RD_LAT-1];
    cmp_mag   = bus.rd_data;
    cmp_dist  = cmp_addr - p1_addr_q;
    far       = (p1_mag_q == ZERO_MAG) || (cmp_dist >= SEP_ADDR);
    p1_addr_d = p1_addr_q;
    p1_mag_d  = p1_mag_q;
    p2_addr_d = p2_addr_q;
    p2_mag_d  = p2_mag_q;
    if (clr_peaks) begin
      p1_addr_d = ZERO_ADDR;
      p1_mag_d  = ZERO_MAG;
      p2_addr_d = ZERO_ADDR;
      p2_mag_d  = ZERO_MAG;
    end else if (cmp_vld) begin
      if (cmp_mag > p1_mag_q) begin
        // A close neighbour only refines the current lobe; peak2 is kept
        if (far) begin
          p2_addr_d = p1_addr_q;
          p2_mag_d  = p1_mag_q;
        end else begin
          p2_addr_d = p2_addr_q;
          p2_mag_d  = p2_mag_q;
        end
        p1_addr_d = cmp_addr;
        p1_mag_d  = cmp_mag;
      end else if ((cmp_mag > p2_mag_q) && far) begin
        p2_addr_d = cmp_addr;
        p2_mag_d  = cmp_mag;
      end else begin
        p2_addr_d = p2_addr_q;
        p2_mag_d  = p2_mag_q;
      end
    end else begin
      p1_addr_d = p1_addr_q;
      p1_mag_d  = p1_mag_q;
    end
  end

  assign bus.rd_en      = rd_en_q;
  assign bus.rd_addr    = rd_addr_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.peak1_addr = p1_addr_q;
  assign bus.peak1_mag  = p1_mag_q;
  assign bus.peak2_addr = p2_addr_q;
  assign bus.peak2_mag  = p2_mag_q;

endmodule

// File: tb/tb_spectrum_peak_ctrl.sv
// Directed bench for spectrum_peak_ctrl: one instance at RD_LAT=1, one at
// RD_LAT=3, each fed by a behavioural RAM read port over a shared image.
module tb_spectrum_peak_ctrl;

  localparam int N_RD = 2047;

  typedef struct packed {
    logic [11:0] b0;
    logic [15:0] v0;
    logic [11:0] b1;
    logic [15:0] v1;
    logic [11:0] b2;
    logic [15:0] v2;
    logic [11:0] p1a;
    logic [15:0] p1m;
    logic [11:0] p2a;
    logic [15:0] p2m;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spectrum_peak_ctrl_if #(.ADDR_W(12), .DATA_W(16)) ifa ();
  spectrum_peak_ctrl_if #(.ADDR_W(12), .DATA_W(16)) ifb ();

  spectrum_peak_ctrl #(.RD_LAT(1)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  spectrum_peak_ctrl #(.RD_LAT(3)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  logic [15:0] ram [4096];
  logic [15:0] b_pipe1, b_pipe2;

  // RAM read ports: one cycle for A, three cycles for B
  always @(posedge clk) begin
    ifa.rd_data <= ifa.rd_en ? ram[ifa.rd_addr] : 16'd0;
    b_pipe1     <= ifb.rd_en ? ram[ifb.rd_addr] : 16'd0;
    b_pipe2     <= b_pipe1;
    ifb.rd_data <= b_pipe2;
  end

  logic        sel_b;
  logic        m_rd_en, m_busy, m_done;
  logic [11:0] m_rd_addr, m_p1a, m_p2a;
  logic [15:0] m_p1m, m_p2m;
  assign m_rd_en   = sel_b ? ifb.rd_en      : ifa.rd_en;
  assign m_busy    = sel_b ? ifb.busy       : ifa.busy;
  assign m_done    = sel_b ? ifb.done       : ifa.done;
  assign m_rd_addr = sel_b ? ifb.rd_addr    : ifa.rd_addr;
  assign m_p1a     = sel_b ? ifb.peak1_addr : ifa.peak1_addr;
  assign m_p1m     = sel_b ? ifb.peak1_mag  : ifa.peak1_mag;
  assign m_p2a     = sel_b ? ifb.peak2_addr : ifa.peak2_addr;
  assign m_p2m     = sel_b ? ifb.peak2_mag  : ifa.peak2_mag;

  int n_checks = 0;
  int n_errs   = 0;
  int bad_addr = 0;

  // Out-of-band read monitor (DC bin or above the single-sided span)
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (ifa.rd_en && (ifa.rd_addr == 12'd0 || ifa.rd_addr > 12'd2047)) bad_addr++;
      if (ifb.rd_en && (ifb.rd_addr == 12'd0 || ifb.rd_addr > 12'd2047)) bad_addr++;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errs++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel_b) ifb.start = v;
    else       ifa.start = v;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rd_en"},   int'(m_rd_en),   0);
    check({tag, "_rd_addr"}, int'(m_rd_addr), 0);
    check({tag, "_busy"},    int'(m_busy),    0);
    check({tag, "_done"},    int'(m_done),    0);
    check({tag, "_p1a"},     int'(m_p1a),     0);
    check({tag, "_p1m"},     int'(m_p1m),     0);
    check({tag, "_p2a"},     int'(m_p2a),     0);
    check({tag, "_p2m"},     int'(m_p2m),     0);
  endtask

  task automatic load(input vec_t v);
    for (int i = 0; i < 4096; i++) ram[i] = 16'd0;
    ram[v.b0] = v.v0;
    ram[v.b1] = v.v1;
    ram[v.b2] = v.v2;
  endtask

  // Arms one scan and measures it; a missing done leaves lat at -1
  task automatic run_scan(input int toggle_at, output int lat, output int busy_cnt,
                          output int rd_cnt, output int done_cnt);
    int c0;
    int dcyc;
    c0 = -1; dcyc = -1; lat = -1;
    busy_cnt = 0; rd_cnt = 0; done_cnt = 0;
    @(negedge clk);
    set_start(1'b1);
    for (int cyc = 0; cyc < 5000; cyc++) begin
      @(negedge clk);
      if (m_rd_en) begin
        rd_cnt++;
        if (c0 < 0) c0 = cyc;
      end
      if (m_busy) busy_cnt++;
      if (m_done) begin
        done_cnt++;
        if (dcyc < 0) dcyc = cyc;
      end
      if (cyc == 2) set_start(1'b0);
      if (toggle_at > 0 && cyc == toggle_at) set_start(1'b1);
      if (toggle_at > 0 && cyc == toggle_at + 2) set_start(1'b0);
      if (dcyc >= 0 && cyc >= dcyc + 4) break;
    end
    if (dcyc >= 0 && c0 >= 0) lat = dcyc - c0;
  endtask

  task automatic scan_and_check(input string tag, input int toggle_at,
                                input int exp_lat, input vec_t v);
    int lat, busy_cnt, rd_cnt, done_cnt;
    run_scan(toggle_at, lat, busy_cnt, rd_cnt, done_cnt);
    check({tag, "_latency"}, lat,      exp_lat);
    check({tag, "_busy"},    busy_cnt, exp_lat);
    check({tag, "_reads"},   rd_cnt,   N_RD);
    check({tag, "_done"},    done_cnt, 1);
    check({tag, "_p1a"},     int'(m_p1a), int'(v.p1a));
    check({tag, "_p1m"},     int'(m_p1m), int'(v.p1m));
    check({tag, "_p2a"},     int'(m_p2a), int'(v.p2a));
    check({tag, "_p2m"},     int'(m_p2m), int'(v.p2m));
    check({tag, "_oob"},     bad_addr, 0);
  endtask

  vec_t vecs [6];

  initial begin
    int found;
    // bin/value triples (unused slots park a zero at bin 4095) -> peak1, peak2
    vecs[0] = '{12'd100, 16'd5000, 12'd500, 16'd3000, 12'd4095, 16'd0,
                12'd100, 16'd5000, 12'd500, 16'd3000};
    vecs[1] = '{12'd100, 16'd5000, 12'd101, 16'd4900, 12'd400, 16'd1000,
                12'd100, 16'd5000, 12'd400, 16'd1000};
    vecs[2] = '{12'd100, 16'd3000, 12'd102, 16'd6000, 12'd700, 16'd2000,
                12'd102, 16'd6000, 12'd700, 16'd2000};
    vecs[3] = '{12'd0, 16'd65535, 12'd200, 16'd7000, 12'd600, 16'd7000,
                12'd200, 16'd7000, 12'd600, 16'd7000};
    vecs[4] = '{12'd3000, 16'd60000, 12'd4095, 16'd0, 12'd4095, 16'd0,
                12'd0, 16'd0, 12'd0, 16'd0};
    vecs[5] = '{12'd1, 16'd50, 12'd2047, 16'd100, 12'd4095, 16'd0,
                12'd2047, 16'd100, 12'd1, 16'd50};

    rst_n     = 1'b0;
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    sel_b     = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset_a");
    sel_b = 1'b1;
    #1;
    check_zero("reset_b");
    sel_b = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      load(vecs[i]);
      scan_and_check($sformatf("vec%0d", i), -1, 2048, vecs[i]);
    end

    // start toggles mid-scan are ignored, then a fresh edge rescans new data
    load(vecs[0]);
    scan_and_check("toggle", 500, 2048, vecs[0]);
    load(vecs[2]);
    scan_and_check("rearm", -1, 2048, vecs[2]);

    // RD_LAT=3 instance: reset in the middle of a scan, then a full rescan
    sel_b = 1'b1;
    load(vecs[1]);
    @(negedge clk);
    ifb.start = 1'b1;
    found = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (k == 2) ifb.start = 1'b0;
      if (ifb.rd_en && ifb.rd_addr == 12'd900) begin
        found = 1;
        break;
      end
    end
    check("midscan_reach_900", found, 1);
    rst_n = 1'b0;
    #1;
    check_zero("midscan_rst");
    @(negedge clk);
    rst_n = 1'b1;
    load(vecs[0]);
    scan_and_check("lat3", -1, 2050, vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
